// File: rtl/demux2_route_pkg.sv
// Shared widths, port indices and the queued entry type for the two-way routing stage.
package demux_route_pkg;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic             sel;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } route_entry_t;

endpackage

// File: rtl/demux2_route_if.sv
// Producer and consumer handshake bundle of the routing stage; slave is the stage's view.
interface demux2_route_if #(
  parameter int WIDTH = demux_route_pkg::WIDTH,
  parameter int TAG_W = demux_route_pkg::TAG_W,
  parameter int CNT_W = demux_route_pkg::CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_select;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [TAG_W-1:0] out0_tag;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [TAG_W-1:0] out1_tag;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;

  modport slave (
    input  in_valid, in_select, in_data, in_tag, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_tag,
           out1_valid, out1_data, out1_tag, cnt0, cnt1, busy
  );

  modport master (
    output in_valid, in_select, in_data, in_tag, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_tag,
           out1_valid, out1_data, out1_tag, cnt0, cnt1, busy
  );

endinterface

// File: rtl/demux2_route_fifo2.sv
// Two-entry in-order queue of route entries. Unoccupied slots are held at zero so the
// head reads as all zeros whenever the queue is empty.
module demux2_fifo2
  import demux_route_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  route_entry_t push_entry,
  input  logic         pop,
  output route_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  route_entry_t slot0;
  route_entry_t slot1;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = slot0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // A push paired with a pop can only happen at count 1, so the new entry lands in the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (empty) slot0 <= push_entry;
          else       slot1 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          slot0 <= push_entry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/demux2_route.sv
// Routing stage: queues {select, tag, data} and offers the head only on its selected port,
// so a stalled head blocks everything behind it. Counts completed transfers per port.
module demux2_route
  import demux_route_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  demux2_route_if.slave  bus
);

  route_entry_t     head;
  route_entry_t     push_entry;
  logic [1:0]       count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             take0;
  logic             take1;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  assign push_entry = '{sel: bus.in_select, tag: bus.in_tag, data: bus.in_data};
  assign push       = bus.in_valid && !full;

  demux2_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign bus.in_ready   = !full;
  assign bus.out0_valid = !empty && (head.sel == PORT0);
  assign bus.out1_valid = !empty && (head.sel == PORT1);
  assign bus.out0_data  = head.data;
  assign bus.out0_tag   = head.tag;
  assign bus.out1_data  = head.data;
  assign bus.out1_tag   = head.tag;
  assign bus.busy       = (count != 2'd0);

  assign take0 = bus.out0_valid && bus.out0_ready;
  assign take1 = bus.out1_valid && bus.out1_ready;
  assign pop   = take0 || take1;

  // Counters wrap silently at the top of their range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (take0) cnt0_q <= cnt0_q + 1'b1;
      if (take1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule
